// File: rtl/imem_ctrl.sv
// imem_ctrl: arbitrates one synchronous instruction memory between the
// fetch port and a data-side read port, and streams program loads into it.
//
// Build option: define IMEM_CTRL_BOUNDS_CHK_EN to add o_addr_err. With it,
// out-of-range or misaligned reads return a NOP instead of touching memory.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_if_* / o_if_*           fetch request, grant, read data
//   i_dp_* / o_dp_*           data-port request, grant, read data
//   i_ld_* / o_ld_*           program-load start, word stream, done pulse
//   o_cpu_stall               core holds its pipeline during a load
//   o_mem_* / i_mem_rdata     single-port memory, 1-cycle read latency
//   o_addr_err                bad read address flag (bounds build only)
module imem_ctrl #(
    parameter int  N        = 2048,
    parameter int  MAX_WAIT = 4,
    localparam int AW       = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_if_req,
    input  logic [31:0]   i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [31:0]   o_if_rdata,
    input  logic          i_dp_req,
    input  logic [31:0]   i_dp_addr,
    output logic          o_dp_gnt,
    output logic          o_dp_rvalid,
    output logic [31:0]   o_dp_rdata,
`ifdef IMEM_CTRL_BOUNDS_CHK_EN
    output logic          o_addr_err,
`endif
    input  logic          i_ld_start,
    input  logic [AW-1:0] i_ld_base,
    input  logic [AW:0]   i_ld_len,
    input  logic          i_ld_valid,
    input  logic [31:0]   i_ld_data,
    output logic          o_ld_ready,
    output logic          o_ld_done,
    output logic          o_cpu_stall,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_LOAD
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    starv_q, starv_d;
    logic [AW-1:0] ptr_q, ptr_nxt;
    logic [AW:0]   rem_q;
    logic          if_rv_q, dp_rv_q;
    logic          if_err_q, dp_err_q;
    logic          done_q, done_d;
    logic [31:0]   if_hold_q, dp_hold_q;
    logic          if_gnt, dp_gnt, ld_xfer;
    logic [AW-1:0] if_idx, dp_idx;
    logic          if_bad, dp_bad;
    logic [31:0]   if_rdata, dp_rdata;

    assign if_idx = i_if_addr[AW+1:2];
    assign dp_idx = i_dp_addr[AW+1:2];

`ifdef IMEM_CTRL_BOUNDS_CHK_EN
    assign if_bad = (i_if_addr[31:AW+2] != '0)
                  | (i_if_addr[1:0] != 2'b00);
    assign dp_bad = (i_dp_addr[31:AW+2] != '0)
                  | (i_dp_addr[1:0] != 2'b00);
`else
    // Upper and sub-word address bits are deliberately dropped here.
    logic unused_addr;
    assign unused_addr = ^{i_if_addr[31:AW+2], i_if_addr[1:0],
                           i_dp_addr[31:AW+2], i_dp_addr[1:0]};
    assign if_bad = 1'b0;
    assign dp_bad = 1'b0;
`endif

    assign ptr_nxt = (ptr_q == AW'(N - 1)) ? '0 : ptr_q + AW'(1);

    always_comb begin
        state_d     = state_q;
        starv_d     = starv_q;
        if_gnt      = 1'b0;
        dp_gnt      = 1'b0;
        done_d      = 1'b0;
        ld_xfer     = 1'b0;
        o_ld_ready  = 1'b0;
        o_cpu_stall = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        // Every combinational output reads 0 while reset is held.
        if (!i_rst) begin
            unique case (state_q)
                S_RUN: begin
                    if (i_if_req && i_dp_req) begin
                        // DP has lost MAX_WAIT times in a row: its turn.
                        if (starv_q == 4'(MAX_WAIT)) begin
                            dp_gnt  = 1'b1;
                            starv_d = '0;
                        end else begin
                            if_gnt  = 1'b1;
                            starv_d = starv_q + 4'd1;
                        end
                    end else if (i_dp_req) begin
                        dp_gnt  = 1'b1;
                        starv_d = '0;
                    end else if (i_if_req) begin
                        if_gnt = 1'b1;
                    end
                    if (if_gnt) begin
                        o_mem_en   = !if_bad;
                        o_mem_addr = if_idx;
                    end
                    if (dp_gnt) begin
                        o_mem_en   = !dp_bad;
                        o_mem_addr = dp_idx;
                    end
                    if (i_ld_start) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    o_cpu_stall = 1'b1;
                    if (rem_q == '0) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    o_cpu_stall = 1'b1;
                    o_ld_ready  = 1'b1;
                    if (i_ld_valid) begin
                        ld_xfer     = 1'b1;
                        o_mem_en    = 1'b1;
                        o_mem_we    = 1'b1;
                        o_mem_addr  = ptr_q;
                        o_mem_wdata = i_ld_data;
                        if (rem_q == (AW+1)'(1)) begin
                            state_d = S_RUN;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_RUN;
            starv_q   <= '0;
            ptr_q     <= '0;
            rem_q     <= '0;
            if_rv_q   <= 1'b0;
            dp_rv_q   <= 1'b0;
            if_err_q  <= 1'b0;
            dp_err_q  <= 1'b0;
            done_q    <= 1'b0;
            if_hold_q <= '0;
            dp_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            starv_q  <= starv_d;
            if_rv_q  <= if_gnt;
            dp_rv_q  <= dp_gnt;
            if_err_q <= if_gnt & if_bad;
            dp_err_q <= dp_gnt & dp_bad;
            done_q   <= done_d;
            if (if_rv_q) begin
                if_hold_q <= if_rdata;
            end
            if (dp_rv_q) begin
                dp_hold_q <= dp_rdata;
            end
            if (state_q == S_RUN && i_ld_start) begin
                ptr_q <= i_ld_base;
                rem_q <= i_ld_len;
            end else if (ld_xfer) begin
                ptr_q <= ptr_nxt;
                rem_q <= rem_q - (AW+1)'(1);
            end
        end
    end

    assign if_rdata = if_err_q ? NOP : i_mem_rdata;
    assign dp_rdata = dp_err_q ? NOP : i_mem_rdata;

    assign o_if_gnt    = if_gnt;
    assign o_dp_gnt    = dp_gnt;
    assign o_if_rvalid = if_rv_q & ~i_rst;
    assign o_dp_rvalid = dp_rv_q & ~i_rst;
    assign o_if_rdata  = i_rst ? '0 : (if_rv_q ? if_rdata : if_hold_q);
    assign o_dp_rdata  = i_rst ? '0 : (dp_rv_q ? dp_rdata : dp_hold_q);
    assign o_ld_done   = done_q & ~i_rst;

`ifdef IMEM_CTRL_BOUNDS_CHK_EN
    assign o_addr_err = (if_err_q | dp_err_q) & ~i_rst;
`endif

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
- Sequencer/arbiter in front of a single-port, synchronous-read 32-bit instruction memory of N words.
- Shares the memory read port between two requesters: instruction fetch (IF) and a data-side read port (DP), used for load-from-text and debug reads.
- Runs a program-load sequence that streams words into the memory while the core is stalled.
- Sits between the core's fetch stage / LSU / boot loader and the memory macro.

Parameters:
N, 2048, memory depth in 32-bit words; AW = $clog2(N) is derived.
MAX_WAIT, 4, consecutive DP denials before DP is forced to win one arbitration cycle; range 1..15.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous, active-high reset
i_if_req  in  1  fetch read request
i_if_addr  in  32  fetch byte address
o_if_gnt  out  1  fetch request accepted this cycle
o_if_rvalid  out  1  fetch data valid
o_if_rdata  out  32  fetch instruction word
i_dp_req  in  1  data-port read request
i_dp_addr  in  32  data-port byte address
o_dp_gnt  out  1  DP request accepted this cycle
o_dp_rvalid  out  1  DP data valid
o_dp_rdata  out  32  DP read word
i_ld_start  in  1  begin program load (pulse)
i_ld_base  in  AW  first word index to write, sampled with i_ld_start
i_ld_len  in  AW+1  number of words to write, sampled with i_ld_start
i_ld_valid  in  1  loader word valid
i_ld_data  in  32  loader word
o_ld_ready  out  1  controller accepts loader word
o_ld_done  out  1  one-cycle pulse when load completes
o_cpu_stall  out  1  core must hold PC/pipeline
o_mem_en  out  1  memory access enable
o_mem_we  out  1  memory write enable
o_mem_addr  out  AW  memory word index
o_mem_wdata  out  32  memory write data
i_mem_rdata  in  32  memory read data, valid the cycle after o_mem_en & !o_mem_we

Behaviour:
- Clock and reset: one clock i_clk. Reset is synchronous, active-high, named i_rst.
- Outputs under reset: all outputs 0. State = RUN; starvation counter = 0; no read in flight.
- States:
  - RUN: RUN -> DRAIN on i_ld_start.
  - DRAIN: exactly 1 cycle; lets any in-flight read return. DRAIN -> LOAD, or DRAIN -> RUN if the sampled length is 0 (o_ld_done pulses on that transition).
  - LOAD: LOAD -> RUN after the last word is written.
- Grants (RUN only) are combinational in the request cycle:
  - Address index = addr[AW+1:2]; bits [1:0] are ignored.
  - Default: IF wins when both IF and DP request.
  - The starvation counter increments on each cycle DP requests and loses. When it equals MAX_WAIT, DP wins the next contested cycle and the counter clears.
  - The counter also clears on any DP grant.
- Read latency: exactly 1 cycle. o_X_rvalid is asserted the cycle after o_X_gnt, with o_X_rdata = i_mem_rdata. rdata holds its last value when rvalid = 0.
- Requesters keep req/addr stable until granted. The controller never drops a granted read.
- o_cpu_stall = 1 in DRAIN and LOAD, otherwise 0. No grants are issued while stalled.
- i_ld_start outside RUN is ignored.
- LOAD handshake:
  - o_ld_ready = 1 throughout LOAD.
  - A word transfers when i_ld_valid & o_ld_ready. That cycle: o_mem_en = o_mem_we = 1, o_mem_addr = write pointer, o_mem_wdata = i_ld_data.
  - The write pointer starts at i_ld_base and increments per word, wrapping from N-1 to 0.
  - On the final word (remaining count 1 -> 0): o_ld_done pulses in the following cycle, in which the state is RUN and stall is 0.
- Memory port: one access per cycle. Reads only in RUN, writes only in LOAD.
- Reset mid-load: the load is abandoned and no o_ld_done is issued. Words already written stay in memory.
- i_ld_len > N is permitted; the pointer wraps and overwrites.

Optional Feature:
- Macro: IMEM_CTRL_BOUNDS_CHK_EN.
- When defined:
  - Adds output o_addr_err (1 bit, reset 0).
  - A granted read whose byte address is >= 4*N, or has addr[1:0] != 0, still occupies the cycle but does not enable the memory.
  - The following cycle: rvalid = 1, rdata = 32'h0000_0013 (NOP), o_addr_err = 1 for one cycle.
- When undefined: no o_addr_err port; the upper address bits are silently truncated and misalignment is ignored.

Test Plan:
- IF reads 0x0, 0x4, 0x8 back-to-back, DP idle -> o_if_gnt = 1 each cycle; o_if_rvalid follows 1 cycle later each time with mem[0], mem[1], mem[2]; no DP activity.
- IF and DP request every cycle, MAX_WAIT = 4 -> IF granted 4 cycles, DP granted on cycle 5, pattern repeats; each DP rvalid arrives 1 cycle after its grant.
- i_ld_start with base = 10, len = 3, words AAAA0001..AAAA0003 with a 1-cycle valid gap -> stall = 1 from the cycle after start; writes land at 10, 11, 12; o_ld_done pulses once; IF fetch of 0x28 afterwards returns AAAA0001.
- i_ld_start issued in the cycle an IF read is granted -> that read's rvalid still fires in DRAIN with correct data; no write occurs before LOAD.
- i_rst asserted after 1 of 3 load words -> all outputs 0 next cycle; state RUN; no o_ld_done; mem[base] updated, the rest unchanged.
- IMEM_CTRL_BOUNDS_CHK_EN with N = 2048: IF reads 0x2000 and 0x6 -> each returns 0x00000013 with o_addr_err = 1, and o_mem_en = 0 in the grant cycle.
